// File: rtl/mul_div_unit.sv
// mul_div_unit -- iterative multiply/divide unit owning the MIPS HI/LO pair.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-high reset
//   start     request strobe, sampled on the rising edge of clk
//   op        0=NONE 1=MULT 2=MULTU 3=DIV 4=DIVU 5=MTHI 6=MTLO 7=reserved
//   a, b      operands (a is also the MTHI/MTLO source)
//   busy      high while a multiply/divide is in flight
//   done      one-cycle pulse when HI/LO receive a new mul/div result
//   hi, lo    HI/LO registers
//   div_zero  last accepted divide had b == 0
//
// Optional build macro MDU_FAST_MULT_EN: MULT/MULTU use a single-cycle
// product and finish one edge after acceptance. Divides stay iterative.
module mul_div_unit #(
    parameter int BitWidth = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [2:0]          op,
    input  logic [BitWidth-1:0] a,
    input  logic [BitWidth-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [BitWidth-1:0] hi,
    output logic [BitWidth-1:0] lo,
    output logic                div_zero
);

    localparam int CNT_W = $clog2(BitWidth);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    function automatic logic [BitWidth-1:0] cond_neg(input logic [BitWidth-1:0] v,
                                                     input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*BitWidth-1:0] cond_neg2(input logic [2*BitWidth-1:0] v,
                                                        input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    state_t                  state;
    logic [CNT_W-1:0]        count;
    logic                    is_div;
    logic                    neg_res;
    logic                    neg_rem;
    logic                    b_zero;

    // Working registers: acc holds {partial product, multiplier} for a
    // multiply or {partial remainder, dividend/quotient} for a divide;
    // opnd holds |a| (multiplicand) or |b| (divisor).
    logic [2*BitWidth-1:0]   acc;
    logic [BitWidth-1:0]     opnd;

    logic signed [BitWidth-1:0] a_s, b_s;
    logic                    op_signed, a_neg, b_neg;
    logic [BitWidth-1:0]     a_mag, b_mag;
    logic                    is_mul_req, is_div_req, accept;

    logic [BitWidth:0]       mul_sum;
    logic [2*BitWidth-1:0]   mul_next;
    logic [2*BitWidth:0]     div_shift;
    logic [BitWidth:0]       div_top, div_diff;
    logic                    div_ge;
    logic [2*BitWidth-1:0]   div_next;

    assign a_s        = a;
    assign b_s        = b;
    assign op_signed  = (op == OP_MULT) || (op == OP_DIV);
    assign a_neg      = op_signed && (a_s < 0);
    assign b_neg      = op_signed && (b_s < 0);
    assign a_mag      = cond_neg(a, a_neg);
    assign b_mag      = cond_neg(b, b_neg);
    assign is_mul_req = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div_req = (op == OP_DIV) || (op == OP_DIVU);
    assign accept     = start && (state == IDLE) && (is_mul_req || is_div_req);
    assign busy       = (state != IDLE);

`ifdef MDU_FAST_MULT_EN
    logic [2*BitWidth-1:0]   fast_prod;
    assign fast_prod = {{BitWidth{1'b0}}, a_mag} * {{BitWidth{1'b0}}, b_mag};
`endif

    always_comb begin
        // Shift-add: add multiplicand to the upper half when the current
        // multiplier bit is set, then shift the whole accumulator right.
        mul_sum  = {1'b0, acc[2*BitWidth-1:BitWidth]}
                 + {1'b0, (acc[0] ? opnd : {BitWidth{1'b0}})};
        mul_next = {mul_sum, acc[BitWidth-1:1]};
        // Restoring divide: shift left, trial-subtract the divisor. A zero
        // divisor always "fits", giving an all-ones quotient and rem = a.
        div_shift = {acc, 1'b0};
        div_top   = div_shift[2*BitWidth:BitWidth];
        div_diff  = div_top - {1'b0, opnd};
        div_ge    = (div_top >= {1'b0, opnd});
        div_next  = {(div_ge ? div_diff[BitWidth-1:0] : div_top[BitWidth-1:0]),
                     div_shift[BitWidth-1:1], div_ge};
    end

    // Control and architectural state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            b_zero   <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
`ifdef MDU_FAST_MULT_EN
                        state <= is_mul_req ? FIX : CALC;
`else
                        state <= CALC;
`endif
                        count    <= CNT_W'(BitWidth - 1);
                        div_zero <= 1'b0;
                        is_div   <= is_div_req;
                        neg_res  <= a_neg ^ b_neg;
                        neg_rem  <= a_neg && is_div_req;
                        b_zero   <= (b == '0);
                    end else if (start && op == OP_MTHI) begin
                        hi <= a;
                    end else if (start && op == OP_MTLO) begin
                        lo <= a;
                    end
                end
                CALC: begin
                    count <= count - 1'b1;
                    if (count == '0) state <= FIX;
                end
                FIX: begin
                    if (is_div) begin
                        lo       <= cond_neg(acc[BitWidth-1:0], neg_res);
                        hi       <= cond_neg(acc[2*BitWidth-1:BitWidth], neg_rem);
                        div_zero <= b_zero;
                    end else begin
                        {hi, lo} <= cond_neg2(acc, neg_res);
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath registers (no reset; only meaningful while busy)
    always_ff @(posedge clk) begin
        if (accept) begin
            if (is_mul_req) begin
`ifdef MDU_FAST_MULT_EN
                acc <= fast_prod;
`else
                acc <= {{BitWidth{1'b0}}, b_mag};
`endif
                opnd <= a_mag;
            end else begin
                acc  <= {{BitWidth{1'b0}}, a_mag};
                opnd <= b_mag;
            end
        end else if (state == CALC) begin
            acc <= is_div ? div_next : mul_next;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed testbench for mul_div_unit (BitWidth = 32).
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int chk_pass  = 0;
    int chk_total = 0;

`ifdef MDU_FAST_MULT_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    mul_div_unit #(.BitWidth(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present a request for one edge, scramble a/b afterwards, then wait
    // (bounded) for done. lat = edges after acceptance, or -1 on timeout.
    task automatic run_op(input logic [2:0] t_op, input logic [31:0] t_a,
                          input logic [31:0] t_b, output logic busy_acc, output int lat);
        @(negedge clk);
        start = 1'b1; op = t_op; a = t_a; b = t_b;
        @(posedge clk); #1;
        busy_acc = busy;
        start = 1'b0; op = 3'd0; a = $urandom; b = $urandom;
        lat = -1;
        for (int k = 1; k <= 45; k++) begin
            if (done) begin lat = k - 1; break; end
            @(posedge clk); #1;
        end
        if (done && lat < 0) lat = 45;
    endtask

    task automatic single_req(input logic [2:0] t_op, input logic [31:0] t_a);
        @(negedge clk);
        start = 1'b1; op = t_op; a = t_a; b = $urandom;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_total++; if ({busy, done, div_zero} !== 3'b000) $display("FAIL reset_ctrl: got %b want 000", {busy, done, div_zero}); else chk_pass++;
        chk_total++; if ({hi, lo} !== 64'h0) $display("FAIL reset_hilo: got %h want 0", {hi, lo}); else chk_pass++;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_mult();
        logic ba; int lat;
        run_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, ba, lat);
        chk_total++; if (ba !== 1'b1) $display("FAIL mult_busy: got %b want 1", ba); else chk_pass++;
        chk_total++; if (lat !== MUL_LAT) $display("FAIL mult_latency: got %0d want %0d", lat, MUL_LAT); else chk_pass++;
        chk_total++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFE) $display("FAIL mult_result: got %h want ffffffff_fffffffe", {hi, lo}); else chk_pass++;
        @(posedge clk); #1;
        chk_total++; if ({done, busy} !== 2'b00) $display("FAIL mult_done_pulse: got %b want 00", {done, busy}); else chk_pass++;
    endtask

    task automatic test_multu();
        logic ba; int lat;
        run_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, ba, lat);
        chk_total++; if (lat !== MUL_LAT) $display("FAIL multu_latency: got %0d want %0d", lat, MUL_LAT); else chk_pass++;
        chk_total++; if ({hi, lo} !== 64'h0000_0001_FFFF_FFFE) $display("FAIL multu_result: got %h want 00000001_fffffffe", {hi, lo}); else chk_pass++;
    endtask

    task automatic test_div();
        logic ba; int lat;
        run_op(3'd3, 32'hFFFF_FFF9, 32'h0000_0002, ba, lat);
        chk_total++; if (lat !== DIV_LAT) $display("FAIL div_latency: got %0d want %0d", lat, DIV_LAT); else chk_pass++;
        chk_total++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) $display("FAIL div_neg_dividend: got %h want ffffffff_fffffffd", {hi, lo}); else chk_pass++;
        chk_total++; if (div_zero !== 1'b0) $display("FAIL div_flag: got %b want 0", div_zero); else chk_pass++;
        // 7 / -2 -> q = -3, remainder follows the positive dividend
        run_op(3'd3, 32'h0000_0007, 32'hFFFF_FFFE, ba, lat);
        chk_total++; if ({hi, lo} !== 64'h0000_0001_FFFF_FFFD) $display("FAIL div_neg_divisor: got %h want 00000001_fffffffd", {hi, lo}); else chk_pass++;
        // Most-negative / -1 wraps with no flag
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, ba, lat);
        chk_total++; if ({hi, lo, div_zero} !== {64'h0000_0000_8000_0000, 1'b0}) $display("FAIL div_overflow: got %h/%b want 00000000_80000000/0", {hi, lo}, div_zero); else chk_pass++;
    endtask

    task automatic test_div_zero();
        logic ba; int lat;
        run_op(3'd4, 32'd100, 32'd0, ba, lat);
        chk_total++; if (lat !== DIV_LAT) $display("FAIL divz_latency: got %0d want %0d", lat, DIV_LAT); else chk_pass++;
        chk_total++; if ({hi, lo} !== 64'h0000_0064_FFFF_FFFF) $display("FAIL divz_result: got %h want 00000064_ffffffff", {hi, lo}); else chk_pass++;
        chk_total++; if (div_zero !== 1'b1) $display("FAIL divz_flag: got %b want 1", div_zero); else chk_pass++;
        @(negedge clk);
        start = 1'b1; op = 3'd2; a = 32'd3; b = 32'd4;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd0;
        chk_total++; if (div_zero !== 1'b0) $display("FAIL divz_clear_on_accept: got %b want 0", div_zero); else chk_pass++;
        lat = -1;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk); #1;
            if (done) begin lat = k; break; end
        end
        chk_total++; if (lat !== MUL_LAT) $display("FAIL divz_follow_latency: got %0d want %0d", lat, MUL_LAT); else chk_pass++;
        chk_total++; if ({hi, lo} !== 64'h0000_0000_0000_000C) $display("FAIL divz_follow_result: got %h want 0000000c", {hi, lo}); else chk_pass++;
    endtask

    task automatic test_move();
        logic ba; int lat;
        run_op(3'd4, 32'd1, 32'd0, ba, lat);
        single_req(3'd6, 32'h0000_ABCD);
        chk_total++; if (lo !== 32'h0000_ABCD) $display("FAIL mtlo_value: got %h want 0000abcd", lo); else chk_pass++;
        chk_total++; if ({done, busy, div_zero} !== 3'b001) $display("FAIL mtlo_side_effects: got %b want 001", {done, busy, div_zero}); else chk_pass++;
        single_req(3'd5, 32'h5555_AAAA);
        chk_total++; if ({hi, lo} !== 64'h5555_AAAA_0000_ABCD) $display("FAIL mthi_value: got %h want 5555aaaa_0000abcd", {hi, lo}); else chk_pass++;
        single_req(3'd7, 32'h1111_1111);
        single_req(3'd0, 32'h2222_2222);
        chk_total++; if ({hi, lo, busy} !== {64'h5555_AAAA_0000_ABCD, 1'b0}) $display("FAIL ignored_ops: got %h/%b want 5555aaaa_0000abcd/0", {hi, lo}, busy); else chk_pass++;
    endtask

    task automatic test_ignore_busy();
        logic ba; int lat; int done_seen;
        @(negedge clk);
        start = 1'b1; op = 3'd2; a = 32'd5; b = 32'd6;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = 3'd4; a = 32'd9; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd0;
        lat = -1;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk); #1;
            if (done) begin lat = k; break; end
        end
`ifdef MDU_FAST_MULT_EN
        chk_total++; if (lat !== 33) $display("FAIL busy_second_latency: got %0d want 33", lat); else chk_pass++;
        chk_total++; if ({hi, lo} !== 64'h0000_0000_0000_0003) $display("FAIL busy_result: got %h want 00000003", {hi, lo}); else chk_pass++;
`else
        chk_total++; if (lat !== 23) $display("FAIL busy_first_latency: got %0d want 23", lat); else chk_pass++;
        chk_total++; if ({hi, lo} !== 64'h0000_0000_0000_001E) $display("FAIL busy_result: got %h want 0000001e", {hi, lo}); else chk_pass++;
`endif
        done_seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (done || busy) done_seen++;
        end
        chk_total++; if (done_seen !== 0) $display("FAIL busy_no_extra_op: got %0d active cycles want 0", done_seen); else chk_pass++;
    endtask

    task automatic test_back_to_back();
        logic ba; int lat;
        run_op(3'd2, 32'd7, 32'd8, ba, lat);
        chk_total++; if ({busy, hi, lo} !== {1'b0, 64'd56}) $display("FAIL b2b_first: got %b/%h want 0/00000038", busy, {hi, lo}); else chk_pass++;
        run_op(3'd4, 32'd100, 32'd7, ba, lat);
        chk_total++; if (lat !== DIV_LAT) $display("FAIL b2b_latency: got %0d want %0d", lat, DIV_LAT); else chk_pass++;
        chk_total++; if ({hi, lo} !== 64'h0000_0002_0000_000E) $display("FAIL b2b_result: got %h want 00000002_0000000e", {hi, lo}); else chk_pass++;
    endtask

    task automatic test_reset_mid_op();
        int active;
        @(negedge clk);
        start = 1'b1; op = 3'd4; a = 32'd50; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_total++; if ({busy, done} !== 2'b00) $display("FAIL rst_mid_ctrl: got %b want 00", {busy, done}); else chk_pass++;
        chk_total++; if ({hi, lo} !== 64'h0) $display("FAIL rst_mid_hilo: got %h want 0", {hi, lo}); else chk_pass++;
        @(negedge clk);
        reset = 1'b0;
        active = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (done || busy || hi != 0 || lo != 0) active++;
        end
        chk_total++; if (active !== 0) $display("FAIL rst_mid_abandon: got %0d active cycles want 0", active); else chk_pass++;
        single_req(3'd5, 32'h0000_1234);
        chk_total++; if ({hi, lo} !== 64'h0000_1234_0000_0000) $display("FAIL rst_mthi: got %h want 00001234_00000000", {hi, lo}); else chk_pass++;
        chk_total++; if ({done, busy} !== 2'b00) $display("FAIL rst_mthi_done: got %b want 00", {done, busy}); else chk_pass++;
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_div_zero();
        test_move();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", chk_pass, chk_total);
        $finish;
    end

endmodule
